// File: rtl/fft_uart_frame_sender_if.sv
// Bundle between the frame sender, the FFT result RAM and the single uart_tx instance.
// master = frame sender side, slave = RAM/UART/control side.
interface fft_uart_frame_sender_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              start_i;
  logic              abort_i;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_re_i;
  logic [DATA_W-1:0] rd_im_i;
  logic              tx_en_o;
  logic [7:0]        tx_data_o;
  logic              tx_done_i;
  logic              busy_o;
  logic              frame_done_o;

  modport master (
    input  start_i, abort_i, rd_re_i, rd_im_i, tx_done_i,
    output rd_en_o, rd_addr_o, tx_en_o, tx_data_o, busy_o, frame_done_o
  );

  modport slave (
    output start_i, abort_i, rd_re_i, rd_im_i, tx_done_i,
    input  rd_en_o, rd_addr_o, tx_en_o, tx_data_o, busy_o, frame_done_o
  );
endinterface

// File: rtl/fft_uart_frame_sender.sv
// Streams one FFT frame (sync byte + 4 bytes per bin, MSB first) through uart_tx.
// <=3 clk from tx_done_i to next tx_en_o; one byte outstanding, stalls indefinitely on tx_done_i.
module fft_uart_frame_sender #(
  parameter int          N_POINTS  = 256,
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fft_uart_frame_sender_if.master bus
);

  typedef enum logic [2:0] {IDLE, SYNC, RD, LAT, LOAD, WAITB, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_POINTS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   bin_q, bin_d;
  logic [1:0]          byte_q, byte_d;
  logic [2*DATA_W-1:0] shift_q, shift_d;
  logic                sync_q, sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      sync_q  <= sync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    sync_d  = sync_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = SYNC;
          bin_d   = '0;
          byte_d  = '0;
          sync_d  = 1'b1;
        end
      end
      SYNC: state_d = WAITB;
      RD:   state_d = LAT;
      LAT: begin
        shift_d = {bus.rd_re_i, bus.rd_im_i};
        byte_d  = '0;
        state_d = LOAD;
      end
      LOAD: state_d = WAITB;
      WAITB: begin
        // abort only takes effect once the in-flight byte has fully left uart_tx
        if (bus.tx_done_i) begin
          if (bus.abort_i) begin
            state_d = IDLE;
            sync_d  = 1'b0;
          end else if (sync_q) begin
            sync_d  = 1'b0;
            state_d = RD;
          end else if (byte_q != 2'd3) begin
            shift_d = {shift_q[2*DATA_W-9:0], 8'h00};
            byte_d  = byte_q + 2'd1;
            state_d = LOAD;
          end else if (bin_q == LAST_BIN) begin
            state_d = FIN;
          end else begin
            bin_d   = bin_q + ADDR_W'(1);
            state_d = RD;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_en_o      = (state_q == RD);
    bus.rd_addr_o    = (state_q == RD) ? bin_q : '0;
    bus.tx_en_o      = (state_q == SYNC) || (state_q == LOAD);
    bus.tx_data_o    = sync_q ? SYNC_BYTE : shift_q[2*DATA_W-1 -: 8];
    bus.busy_o       = (state_q != IDLE);
    bus.frame_done_o = (state_q == FIN);
  end

endmodule

// File: tb/tb_fft_uart_frame_sender.sv
// Bench for fft_uart_frame_sender: 4-bin frames, RAM re=0x1000+a / im=0x2000+a, UART done 20 clk after en.
module tb_fft_uart_frame_sender;
  localparam int N_POINTS = 4;
  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic spur  = 1'b0;

  fft_uart_frame_sender_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fft_uart_frame_sender #(
    .N_POINTS(N_POINTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // UART model: done pulse 20 clk after each tx_en_o, shares rst_n
  logic [4:0] uart_cnt;
  logic       real_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              uart_cnt <= 5'd0;
    else if (bus.tx_en_o)    uart_cnt <= 5'd20;
    else if (uart_cnt != 0)  uart_cnt <= uart_cnt - 5'd1;
  end
  assign real_done     = (uart_cnt == 5'd1);
  assign bus.tx_done_i = real_done | spur;

  // RAM model: data valid exactly one cycle after rd_en_o, garbage otherwise
  always_ff @(posedge clk) begin
    if (bus.rd_en_o) begin
      bus.rd_re_i <= 16'h1000 + 16'(bus.rd_addr_o);
      bus.rd_im_i <= 16'h2000 + 16'(bus.rd_addr_o);
    end else begin
      bus.rd_re_i <= 16'hDEAD;
      bus.rd_im_i <= 16'hBEEF;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int byte_cnt = 0;
  int frames = 0;
  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] addr_log[$];
  bit         outstanding = 1'b0;
  bit         en_prev = 1'b0;
  logic [7:0] held;
  logic [7:0] exp_b;

  // Scoreboard and protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 1'b0;
      en_prev     = 1'b0;
    end else begin
      if (bus.tx_en_o) begin
        byte_cnt++;
        vectors++;
        if (en_prev) begin
          miscompares++;
          $display("FAIL tx_en_width: byte %0d tx_en_o high 2 cycles, required 1", byte_cnt);
        end
        vectors++;
        if (outstanding) begin
          miscompares++;
          $display("FAIL one_outstanding: byte %0d tx_en_o=1 before tx_done_i, required 0", byte_cnt);
        end
        outstanding = 1'b1;
        held = bus.tx_data_o;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_byte: got %h, required no byte", bus.tx_data_o);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.tx_data_o !== exp_b) begin
            miscompares++;
            $display("FAIL byte_data: byte %0d got %h required %h", byte_cnt, bus.tx_data_o, exp_b);
          end
        end
      end else if (outstanding) begin
        vectors++;
        if (bus.tx_data_o !== held) begin
          miscompares++;
          $display("FAIL data_stable: tx_data_o %h changed, required %h", bus.tx_data_o, held);
        end
      end
      if (real_done) outstanding = 1'b0;
      if (bus.rd_en_o) addr_log.push_back(bus.rd_addr_o);
      if (bus.frame_done_o) frames++;
      en_prev = bus.tx_en_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    exp_q.push_back(8'hA5);
    for (int a = 0; a < N_POINTS; a++) begin
      exp_q.push_back(8'h10);
      exp_q.push_back(8'(a));
      exp_q.push_back(8'h20);
      exp_q.push_back(8'(a));
    end
  endtask

  task automatic clear_log();
    byte_cnt = 0;
    frames   = 0;
    addr_log.delete();
    exp_q.delete();
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
  endtask

  task automatic wait_frame_done(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (bus.frame_done_o) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int n);
    for (int c = 0; c < 3000 && byte_cnt < n; c++) step();
  endtask

  task automatic check_frame_totals(input string tag, input int exp_bytes, input int exp_frames);
    vectors++;
    if (byte_cnt !== exp_bytes) begin
      miscompares++;
      $display("FAIL %s_bytes: got %0d required %0d", tag, byte_cnt, exp_bytes);
    end
    vectors++;
    if (frames !== exp_frames) begin
      miscompares++;
      $display("FAIL %s_frames: got %0d required %0d", tag, frames, exp_frames);
    end
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    spur  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.rd_en_o !== 1'b0)      begin miscompares++; $display("FAIL rst_rd_en: got %b required 0", bus.rd_en_o); end
    vectors++; if (bus.rd_addr_o !== '0)      begin miscompares++; $display("FAIL rst_rd_addr: got %h required 0", bus.rd_addr_o); end
    vectors++; if (bus.tx_en_o !== 1'b0)      begin miscompares++; $display("FAIL rst_tx_en: got %b required 0", bus.tx_en_o); end
    vectors++; if (bus.tx_data_o !== 8'h00)   begin miscompares++; $display("FAIL rst_tx_data: got %h required 00", bus.tx_data_o); end
    vectors++; if (bus.busy_o !== 1'b0)       begin miscompares++; $display("FAIL rst_busy: got %b required 0", bus.busy_o); end
    vectors++; if (bus.frame_done_o !== 1'b0) begin miscompares++; $display("FAIL rst_frame_done: got %b required 0", bus.frame_done_o); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_frame();
    bit seen;
    clear_log();
    push_frame();
    pulse_start();
    vectors++;
    if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL busy_rise: got %b required 1", bus.busy_o); end
    wait_frame_done(seen);
    vectors++;
    if (seen !== 1'b1) begin miscompares++; $display("FAIL frame_done_seen: got %b required 1", seen); end
    step();
    vectors++;
    if (bus.frame_done_o !== 1'b0) begin miscompares++; $display("FAIL frame_done_width: got %b required 0", bus.frame_done_o); end
    vectors++;
    if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL busy_fall: got %b required 0", bus.busy_o); end
    check_frame_totals("full", 17, 1);
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL full_missing: %0d bytes unsent, required 0", exp_q.size()); end
    for (int a = 0; a < N_POINTS; a++) begin
      vectors++;
      if (a >= addr_log.size() || addr_log[a] !== ADDR_W'(a)) begin
        miscompares++;
        $display("FAIL rd_addr_seq: read %0d got %0d (of %0d reads) required %0d", a,
                 (a < addr_log.size()) ? int'(addr_log[a]) : -1, addr_log.size(), a);
      end
    end
    vectors++;
    if (addr_log.size() !== N_POINTS) begin miscompares++; $display("FAIL rd_count: got %0d required %0d", addr_log.size(), N_POINTS); end
  endtask

  task automatic test_abort();
    clear_log();
    push_frame();
    pulse_start();
    wait_bytes(6);
    bus.abort_i = 1'b1;
    for (int c = 0; c < 200 && bus.busy_o; c++) step();
    bus.abort_i = 1'b0;
    vectors++;
    if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL abort_idle: busy got %b required 0", bus.busy_o); end
    repeat (60) step();
    check_frame_totals("abort", 6, 0);
    exp_q.delete();
  endtask

  task automatic test_start_ignored();
    bit seen;
    clear_log();
    push_frame();
    pulse_start();
    wait_bytes(3);
    repeat (5) step();
    pulse_start();
    wait_frame_done(seen);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    vectors++;
    if (seen !== 1'b1) begin miscompares++; $display("FAIL ign_frame_done: got %b required 1", seen); end
    repeat (40) step();
    vectors++;
    if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL ign_fin_start: busy got %b required 0", bus.busy_o); end
    check_frame_totals("ignore", 17, 1);
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL ign_missing: %0d bytes unsent, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    clear_log();
    push_frame();
    pulse_start();
    wait_bytes(9);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.busy_o !== 1'b0)     begin miscompares++; $display("FAIL mid_rst_busy: got %b required 0", bus.busy_o); end
    vectors++; if (bus.tx_data_o !== 8'h00) begin miscompares++; $display("FAIL mid_rst_tx_data: got %h required 00", bus.tx_data_o); end
    vectors++; if (bus.tx_en_o !== 1'b0)    begin miscompares++; $display("FAIL mid_rst_tx_en: got %b required 0", bus.tx_en_o); end
    vectors++; if (frames !== 0)            begin miscompares++; $display("FAIL mid_rst_frames: got %0d required 0", frames); end
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    clear_log();
    push_frame();
    pulse_start();
    wait_frame_done(seen);
    step();
    vectors++;
    if (seen !== 1'b1) begin miscompares++; $display("FAIL post_rst_done: got %b required 1", seen); end
    check_frame_totals("post_rst", 17, 1);
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL post_rst_missing: %0d bytes unsent, required 0", exp_q.size()); end
  endtask

  task automatic test_spurious_done();
    bit seen;
    clear_log();
    spur = 1'b1;
    repeat (3) step();
    spur = 1'b0;
    vectors++;
    if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL spur_idle: busy got %b required 0", bus.busy_o); end
    push_frame();
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.frame_done_o) begin
        seen = 1'b1;
        break;
      end
      spur = bus.rd_en_o | bus.tx_en_o;
      step();
    end
    spur = 1'b0;
    step();
    vectors++;
    if (seen !== 1'b1) begin miscompares++; $display("FAIL spur_frame_done: got %b required 1", seen); end
    check_frame_totals("spur", 17, 1);
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL spur_missing: %0d bytes unsent, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_abort();
    test_start_ignored();
    test_reset_mid_frame();
    test_spurious_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
